// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter
//   Shares one combinational integer square-root datapath between NUM_REQ
//   requesters. Round-robin arbitration picks one requester per IDLE visit,
//   the radicand is captured into op_reg, the root/remainder are registered
//   one cycle later and returned on a single response channel tagged with the
//   requester index.
//
//   Optional build macro: SQRT_ARB_CHECK_EN
//     defined   -> every result is checked (Q*Q + R == D and R <= 2Q); a
//                  failure sets the sticky err flag until reset.
//     undefined -> no checker, err is tied low.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : [NUM_REQ] per-requester request valid
//   req_data   : [32*NUM_REQ] packed radicands, requester i on [32i+31:32i]
//   req_ready  : [NUM_REQ] per-requester accept, one-hot or zero
//   rsp_valid  : result valid
//   rsp_ready  : consumer accepts result
//   rsp_id     : [ID_W] owner of the result
//   rsp_q      : [16] floor(sqrt(D))
//   rsp_r      : [17] D - Q*Q
//   err        : sticky self-check failure
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is never a function of anything the requester sees as
// a response, and rsp_valid never drops before rsp_ready has been seen high.

// Combinational non-restoring square root: 16 iterations, one root bit each.
module non_restoring_sqrt (
  input  logic [31:0] d,
  output logic [15:0] q,
  output logic [16:0] r
);

  // Signed partial remainder; 20 bits leaves headroom for the shift by two.
  logic [19:0] rem;
  logic [15:0] root;

  always_comb begin
    rem  = '0;
    root = '0;
    for (int i = 15; i >= 0; i--) begin
      if (rem[19] == 1'b0)
        rem = {rem[17:0], d[2*i +: 2]} - {2'b00, root, 2'b01};
      else
        rem = {rem[17:0], d[2*i +: 2]} + {2'b00, root, 2'b11};
      root = {root[14:0], ~rem[19]};
    end
    // A negative final remainder needs one restoring correction.
    if (rem[19])
      rem = rem + {3'b000, root, 1'b1};
    q = root;
    r = rem[16:0];
  end

endmodule

module sqrt_arbiter #(
  parameter int NUM_REQ = 4,  // 2..8
  parameter int ID_W    = 2   // clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [15:0]             rsp_q,
  output logic [16:0]             rsp_r,
  output logic                    err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] id_reg;
  logic [31:0]     op_reg;

  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] cand;
  logic            found;
  logic            accept;
  logic            load_rsp;
  logic            clear_rsp;

  logic [15:0]     sq_q;
  logic [16:0]     sq_r;

  // The datapath only ever sees the captured operand.
  non_restoring_sqrt u_sqrt (
    .d (op_reg),
    .q (sq_q),
    .r (sq_r)
  );

  // Round-robin search starting one past the last grant, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + 1 + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // rst_n gates ready so nothing is offered while reset is held.
  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && rst_n && found)
      req_ready[winner] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_rsp  = 1'b0;
    clear_rsp = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_CALC;
      ST_CALC: begin
        load_rsp  = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: if (rsp_ready) begin
        clear_rsp = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      id_reg     <= '0;
      op_reg     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_q      <= '0;
      rsp_r      <= '0;
    end else begin
      if (accept) begin
        op_reg     <= req_data[{winner, 5'b00000} +: 32];
        id_reg     <= winner;
        last_grant <= winner;
      end
      if (load_rsp) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_reg;
        rsp_q     <= sq_q;
        rsp_r     <= sq_r;
      end else if (clear_rsp) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef SQRT_ARB_CHECK_EN
  logic [33:0] chk_sum;
  assign chk_sum = 34'(sq_q) * 34'(sq_q) + 34'(sq_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (load_rsp && ((chk_sum != {2'b00, op_reg}) || (sq_r > {sq_q, 1'b0})))
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter: reset values, single-request latency,
// boundary radicands, round-robin fairness, backpressure, reset mid-operation
// and grant wrap-around with gaps between requests.
module tb_sqrt_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           rsp_q;
  logic [16:0]           rsp_r;
  logic                  err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sqrt_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .rsp_r     (rsp_r),
    .err       (err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver / checker tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_req(input int idx, input logic [31:0] d);
    req_data[idx*32 +: 32] = d;
    req_valid[idx]         = 1'b1;
  endtask

  task automatic wait_rsp;
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check("rsp_wait", 64'(rsp_valid), 64'd1);
  endtask

  task automatic check_rsp(input int id, input int q, input int r);
    check("rsp_id", 64'(rsp_id), 64'(id));
    check("rsp_q",  64'(rsp_q),  64'(q));
    check("rsp_r",  64'(rsp_r),  64'(r));
  endtask

  // Lone request from idx with rsp_ready high: accept now, result two edges on.
  task automatic run_one(input int idx, input logic [31:0] d, input int eq, input int er);
    set_req(idx, d);
    #1;
    check("grant", 64'(req_ready), 64'(1 << idx));
    tick;
    req_valid[idx] = 1'b0;
    check("calc_valid", 64'(rsp_valid), 64'd0);
    check("calc_ready", 64'(req_ready), 64'd0);
    tick;
    check("lat_valid", 64'(rsp_valid), 64'd1);
    check_rsp(idx, eq, er);
    check("err", 64'(err), 64'd0);
    tick;
    check("done_valid", 64'(rsp_valid), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0001;
    req_data  = '0;
    rsp_ready = 1'b0;
    #2;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check_rsp(0, 0, 0);
    check("rst_err", 64'(err), 64'd0);
    tick;
    tick;
    req_valid = '0;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    tick;

    // single request, then boundary radicands
    run_one(2, 32'd40000, 200, 0);
    run_one(0, 32'd0, 0, 0);
    run_one(0, 32'd15, 3, 6);
    run_one(0, 32'd4294705156, 65534, 0);
    run_one(0, 32'hFFFF_FFFF, 65535, 131070);

    // fairness: all requesters held high from reset
    rst_n     = 1'b0;
    req_data  = {32'd16, 32'd9, 32'd4, 32'd1};
    req_valid = 4'b1111;
    #1;
    check("rst_ready_all", 64'(req_ready), 64'd0);
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_rsp;
      check_rsp(k % 4, (k % 4) + 1, 0);
      check("resp_ready0", 64'(req_ready), 64'd0);
      tick;
    end
    req_valid = '0;
    check("fair_done", 64'(rsp_valid), 64'd0);

    // backpressure with a pending request (last_grant is 3 here)
    rsp_ready = 1'b0;
    set_req(1, 32'd1000000);
    #1;
    check("bp_grant", 64'(req_ready), 64'b0010);
    tick;
    req_valid[1] = 1'b0;
    set_req(3, 32'd99);
    #1;
    check("bp_calc_ready", 64'(req_ready), 64'd0);
    tick;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check_rsp(1, 1000, 0);
      check("bp_ready", 64'(req_ready), 64'd0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    check("bp_cleared", 64'(rsp_valid), 64'd0);
    check("bp_pending_grant", 64'(req_ready), 64'b1000);
    tick;
    req_valid[3] = 1'b0;
    wait_rsp;
    check_rsp(3, 9, 18);
    tick;

    // reset during CALC
    set_req(0, 32'd169);
    #1;
    check("mid_grant", 64'(req_ready), 64'b0001);
    tick;
    req_valid = 4'b0011;
    rst_n     = 1'b0;
    #1;
    check("mid_valid", 64'(rsp_valid), 64'd0);
    check_rsp(0, 0, 0);
    check("mid_ready", 64'(req_ready), 64'd0);
    tick;
    tick;
    req_valid = '0;
    rst_n     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      check("mid_no_rsp", 64'(rsp_valid), 64'd0);
    end
    req_data[31:0]  = 32'd49;
    req_data[63:32] = 32'd64;
    req_valid       = 4'b0011;
    #1;
    check("mid_first0", 64'(req_ready), 64'b0001);
    tick;
    req_valid[0] = 1'b0;
    wait_rsp;
    check_rsp(0, 7, 0);
    tick;
    check("mid_next1", 64'(req_ready), 64'b0010);
    tick;
    req_valid[1] = 1'b0;
    wait_rsp;
    check_rsp(1, 8, 0);
    tick;

    // gaps and wrap-around
    run_one(1, 32'd4, 2, 0);
    run_one(3, 32'd25, 5, 0);
    set_req(1, 32'd36);
    set_req(3, 32'd81);
    #1;
    check("wrap_grant1", 64'(req_ready), 64'b0010);
    tick;
    req_valid[1] = 1'b0;
    wait_rsp;
    check_rsp(1, 6, 0);
    tick;
    check("wrap_grant3", 64'(req_ready), 64'b1000);
    tick;
    req_valid[3] = 1'b0;
    wait_rsp;
    check_rsp(3, 9, 0);
    check("final_err", 64'(err), 64'd0);
    tick;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sqrt_arbiter.md
# sqrt_arbiter

Shares a single combinational `non_restoring_sqrt` instance (32-bit radicand D, 16-bit root Q, 17-bit remainder R) between `NUM_REQ` requesters. The block runs round-robin arbitration and a valid/ready accept handshake per requester. It registers the operand and the result, and returns each result on one shared response channel tagged with the requester ID. It sits between the client blocks and the sqrt datapath and is the only instantiator of it.

## Interface
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `ID_W`, 2, response ID width; must equal clog2(`NUM_REQ`).
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — reset, asynchronous, active-low.
- `req_valid` input `NUM_REQ` — per-requester request valid.
- `req_data` input 32*`NUM_REQ` — packed radicands; requester i drives bits [32i+31:32i].
- `req_ready` output `NUM_REQ` — per-requester accept; at most one bit high (one-hot or zero).
- `rsp_valid` output 1 — result valid.
- `rsp_ready` input 1 — consumer accepts result.
- `rsp_id` output `ID_W` — index of the requester that owns the result.
- `rsp_q` output 16 — floor(sqrt(D)).
- `rsp_r` output 17 — D − Q².
- `err` output 1 — sticky self-check failure (see Configuration).

## Operation
- FSM has three states:
  - IDLE: arbitrate. On accept → CALC. With no request, stay in IDLE.
  - CALC: `rsp_q`/`rsp_r` registered from sqrt(op_reg); `rsp_valid` set → RESP.
  - RESP: hold outputs; on `rsp_valid & rsp_ready` clear `rsp_valid` → IDLE.
- Arbitration applies in IDLE only. The search starts at (last_grant+1) mod `NUM_REQ` and wraps; the first index with `req_valid` high wins.
- `req_ready[winner]` is combinational from `req_valid` and is high only in IDLE. In every other state `req_ready` = 0.
- Accept is `req_valid[i] & req_ready[i]` at a clock edge. On accept:
  - op_reg ← `req_data[i]`
  - id_reg ← i
  - last_grant ← i
- Requester rules: once `req_valid` is raised it stays high and `req_data` stays stable until accept. The block does not check these rules.
- The sqrt instance input is op_reg only; `req_data` never feeds it directly.
- Outputs `rsp_id`, `rsp_q`, `rsp_r` change only on the CALC→RESP edge and stay stable while `rsp_valid` is high.
- Widths: Q is 16 bits, R is 17 bits, and R ≤ 2Q always holds. Max case: D = 0xFFFFFFFF gives Q = 65535, R = 131070.

## Timing
- Reset values:
  - FSM = IDLE
  - last_grant = `NUM_REQ`−1, so requester 0 has first priority
  - op_reg = 0, id_reg = 0
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_q` = 0, `rsp_r` = 0
  - `err` = 0
  - `req_ready` = 0 while `rst_n` low
- Latency: accept in cycle n → `rsp_valid` high in cycle n+2.
- If `rsp_ready` is high in cycle n+2, the response completes and the earliest next accept is cycle n+3. Peak throughput is 1 result per 3 cycles.
- Backpressure: with `rsp_ready` low, RESP holds indefinitely. No new accept occurs and all `req_ready` stay 0.
- Simultaneous requests: exactly one accept per IDLE visit; the others wait for later IDLE visits.
- A requester that drops out of contention does not move last_grant.
- Reset mid-operation: `rst_n` low in CALC or RESP aborts the operation immediately. The in-flight result is discarded and no `rsp_valid` is produced after reset release.
- `rsp_ready` high while `rsp_valid` is low is ignored.

## Configuration
- Macro `SQRT_ARB_CHECK_EN`.
- Defined: on the CALC→RESP edge the block checks Q*Q + R == op_reg (34-bit arithmetic) and R ≤ 2Q. Any failure sets `err`, which stays set until reset.
- Undefined: the check logic is not compiled and `err` is tied to 0.
- Port list is identical in both builds.

## Test plan
- Single request: requester 2, D=40000, `rsp_ready`=1 → accept cycle n, `rsp_valid` in n+2 with `rsp_id`=2, Q=200, R=0; IDLE again in n+3.
- Boundary values on requester 0, one at a time:
  - D=0 → Q=0, R=0
  - D=15 → Q=3, R=6
  - D=4294705156 → Q=65534, R=0
  - D=4294967295 → Q=65535, R=131070
  - `err` stays 0 with the macro defined.
- Fairness: all 4 `req_valid` held high continuously from reset → responses in ID order 0,1,2,3,0,1… Each requester is granted once per 4 accepts.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP with a new request pending → `rsp_valid`/`rsp_q`/`rsp_r`/`rsp_id` stable and `req_ready`=0 throughout. The pending request is accepted on the cycle after `rsp_ready`=1 completes the response.
- Reset mid-op: accept D=169, assert `rst_n`=0 during CALC → all outputs go to reset values at once. After release, no response with Q=13 appears and requester 0 is served first.
- Gaps: requester 1 alone, then requester 3 alone, then both together → after serving 3, the next grant goes to 1 (wrap from last_grant=3).
